// File: rtl/axis_pkg.sv
// Shared AXI-Stream helpers used by the width converters (serializer/deserializer).
package axis_pkg;

    // Number of tkeep bits needed to cover a tdata bus of the given width.
    function automatic int keep_width(int data_width);
        return (data_width + 7) / 8;
    endfunction

    // Elaboration-time helper: true when a data width is a whole number of bytes.
    function automatic bit byte_aligned(int data_width);
        return (data_width % 8) == 0;
    endfunction

endpackage

// File: rtl/axis_interface.sv
// AXI-Stream bundle with Source (driver) and Sink (receiver) views.
interface axis_interface #(
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8
) ();
    localparam int KEEP_WIDTH = axis_pkg::keep_width(DATA_WIDTH);

    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;

    modport Source (
        output tvalid, tdata, tkeep, tlast, tuser, tid, tdest,
        input  tready
    );

    modport Sink (
        input  tvalid, tdata, tkeep, tlast, tuser, tid, tdest,
        output tready
    );
endinterface

// File: rtl/axis_deserializer.sv
// Narrow-to-wide AXI-Stream width converter: packs RATIO input beats into one
// output word, lane 0 first. An input tlast closes the word early so packet
// boundaries survive; unfilled lanes are zero with keep cleared.
module axis_deserializer
    import axis_pkg::*;
#(
    parameter int IN_WIDTH   = 8,
    parameter int RATIO      = 4,
    parameter int OUT_WIDTH  = IN_WIDTH * RATIO,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    axis_interface.Sink   s_axis,
    axis_interface.Source m_axis
);

    localparam int IN_KEEP  = keep_width(IN_WIDTH);
    localparam int OUT_KEEP = keep_width(OUT_WIDTH);
    localparam int IDX_W    = $clog2(RATIO);

    if (!byte_aligned(IN_WIDTH)) begin : g_width_check
        $error("axis_deserializer: IN_WIDTH must be a multiple of 8");
    end

    // Accumulator state
    logic [IDX_W-1:0]      idx;
    logic [OUT_WIDTH-1:0]  acc_data;
    logic [OUT_KEEP-1:0]   acc_keep;
    logic [USER_WIDTH-1:0] acc_user;
    logic [ID_WIDTH-1:0]   acc_id;
    logic [DEST_WIDTH-1:0] acc_dest;

    // Output holding register
    logic                  out_valid;
    logic [OUT_WIDTH-1:0]  out_data;
    logic [OUT_KEEP-1:0]   out_keep;
    logic                  out_last;
    logic [USER_WIDTH-1:0] out_user;
    logic [ID_WIDTH-1:0]   out_id;
    logic [DEST_WIDTH-1:0] out_dest;

    // Accumulator merged with the current beat
    logic [OUT_WIDTH-1:0]  merge_data;
    logic [OUT_KEEP-1:0]   merge_keep;
    logic [USER_WIDTH-1:0] merge_user;
    logic [ID_WIDTH-1:0]   merge_id;
    logic [DEST_WIDTH-1:0] merge_dest;

    logic ready;
    logic beat;
    logic complete;

    // Input beats carry no byte holes, so tkeep has no effect on the packing.
    logic unused_keep;
    assign unused_keep = ^s_axis.tkeep;

    // Accept whenever the holding register is empty or being drained this cycle.
    assign ready    = !out_valid || m_axis.tready;
    assign beat     = s_axis.tvalid && ready;
    assign complete = beat && ((idx == IDX_W'(RATIO - 1)) || s_axis.tlast);

    assign s_axis.tready = ready;

    // Overlay the incoming beat onto lane idx of the accumulator.
    always_comb begin
        merge_data = acc_data;
        merge_keep = acc_keep;
        for (int l = 0; l < RATIO; l++) begin
            if (idx == IDX_W'(l)) begin
                merge_data[l*IN_WIDTH +: IN_WIDTH] = s_axis.tdata;
                merge_keep[l*IN_KEEP +: IN_KEEP]   = '1;
            end
        end
        merge_user = acc_user | s_axis.tuser;
        // Routing fields belong to the first beat of the word.
        merge_id   = (idx == '0) ? s_axis.tid   : acc_id;
        merge_dest = (idx == '0) ? s_axis.tdest : acc_dest;
    end

    // Lane index and accumulator: fill on each beat, clear when a word completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            acc_data <= '0;
            acc_keep <= '0;
            acc_user <= '0;
            acc_id   <= '0;
            acc_dest <= '0;
        end else if (complete) begin
            idx      <= '0;
            acc_data <= '0;
            acc_keep <= '0;
            acc_user <= '0;
        end else if (beat) begin
            idx      <= idx + IDX_W'(1);
            acc_data <= merge_data;
            acc_keep <= merge_keep;
            acc_user <= merge_user;
            acc_id   <= merge_id;
            acc_dest <= merge_dest;
        end
    end

    // Output register: load on completion (even while the old word drains), else
    // drop valid once the consumer takes the word; frozen while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_user  <= '0;
            out_id    <= '0;
            out_dest  <= '0;
        end else if (complete) begin
            out_valid <= 1'b1;
            out_data  <= merge_data;
            out_keep  <= merge_keep;
            out_last  <= s_axis.tlast;
            out_user  <= merge_user;
            out_id    <= merge_id;
            out_dest  <= merge_dest;
        end else if (m_axis.tready) begin
            out_valid <= 1'b0;
        end
    end

    assign m_axis.tvalid = out_valid;
    assign m_axis.tdata  = out_data;
    assign m_axis.tkeep  = out_keep;
    assign m_axis.tlast  = out_last;
    assign m_axis.tuser  = out_user;
    assign m_axis.tid    = out_id;
    assign m_axis.tdest  = out_dest;

endmodule

// File: tb/tb_axis_deserializer.sv
// Scoreboard bench for axis_deserializer (8-bit in, 4 lanes, 32-bit out).
module tb_axis_deserializer;

    localparam int IN_W  = 8;
    localparam int RATIO = 4;
    localparam int OUT_W = IN_W * RATIO;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [3:0]       keep;
        logic             last;
        logic             user;
        logic [7:0]       id;
        logic [7:0]       dest;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    axis_interface #(.DATA_WIDTH(IN_W),  .USER_WIDTH(1), .ID_WIDTH(8), .DEST_WIDTH(8)) s_if ();
    axis_interface #(.DATA_WIDTH(OUT_W), .USER_WIDTH(1), .ID_WIDTH(8), .DEST_WIDTH(8)) m_if ();

    axis_deserializer #(
        .IN_WIDTH(IN_W), .RATIO(RATIO), .USER_WIDTH(1), .ID_WIDTH(8), .DEST_WIDTH(8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s_axis (s_if),
        .m_axis (m_if)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    n_words = 0;
    word_t q[$];
    word_t acc;
    word_t last_word;
    int    midx = 0;
    logic  rst_prev = 1'b0;
    logic  rand_rdy = 1'b0;
    logic  rdy_force = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Consumer ready: fixed or random, changed just after each edge.
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_if.tready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
        end
    end

    // Monitor + reference model, sampled mid-cycle.
    always @(negedge clk) begin
        logic exp_rdy;
        if (rst) begin
            if (rst_prev) begin
                chk("rst_vld",  64'(m_if.tvalid), 64'd0);
                chk("rst_data", 64'(m_if.tdata),  64'd0);
                chk("rst_keep", 64'(m_if.tkeep),  64'd0);
                chk("rst_last", 64'(m_if.tlast),  64'd0);
                chk("rst_user", 64'(m_if.tuser),  64'd0);
                chk("rst_id",   64'(m_if.tid),    64'd0);
                chk("rst_dest", 64'(m_if.tdest),  64'd0);
            end
            q.delete();
            acc  = '{default: '0};
            midx = 0;
        end else begin
            exp_rdy = (q.size() == 0) || m_if.tready;
            chk("vld", 64'(m_if.tvalid), 64'(q.size() != 0));
            chk("rdy", 64'(s_if.tready), 64'(exp_rdy));
            if (q.size() != 0) begin
                chk("data", 64'(m_if.tdata), 64'(q[0].data));
                chk("keep", 64'(m_if.tkeep), 64'(q[0].keep));
                chk("last", 64'(m_if.tlast), 64'(q[0].last));
                chk("user", 64'(m_if.tuser), 64'(q[0].user));
                chk("id",   64'(m_if.tid),   64'(q[0].id));
                chk("dest", 64'(m_if.tdest), 64'(q[0].dest));
                if (m_if.tready) begin
                    last_word = q.pop_front();
                    n_words++;
                end
            end
            if (s_if.tvalid && exp_rdy) begin
                acc.data[midx*IN_W +: IN_W] = s_if.tdata;
                acc.keep[midx] = 1'b1;
                acc.user = acc.user | s_if.tuser[0];
                if (midx == 0) begin
                    acc.id   = s_if.tid;
                    acc.dest = s_if.tdest;
                end
                if (midx == RATIO - 1 || s_if.tlast) begin
                    acc.last = s_if.tlast;
                    q.push_back(acc);
                    acc  = '{default: '0};
                    midx = 0;
                end else begin
                    midx++;
                end
            end
        end
        rst_prev = rst;
    end

    task automatic send(input logic [7:0] d, input logic l, input logic u,
                        input logic [7:0] id, input logic [7:0] dst);
        logic taken;
        s_if.tdata  = d;
        s_if.tlast  = l;
        s_if.tuser  = u;
        s_if.tid    = id;
        s_if.tdest  = dst;
        s_if.tkeep  = 1'b0;
        s_if.tvalid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            taken = s_if.tready;
            @(posedge clk);
            #1;
            if (taken) return;
        end
        chk("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic idle();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            #1;
            if (q.size() == 0) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int w0;
        int t0;
        idle();
        s_if.tdata = '0; s_if.tid = '0; s_if.tdest = '0; s_if.tkeep = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Full word, back-to-back beats
        send(8'h11, 0, 0, 0, 0);
        send(8'h22, 0, 0, 0, 0);
        send(8'h33, 0, 0, 0, 0);
        send(8'h44, 0, 0, 0, 0);
        idle();
        @(negedge clk);
        chk("latency", 64'(m_if.tvalid), 64'd1);
        drain();
        chk("w1_data", 64'(last_word.data), 64'h44332211);
        chk("w1_keep", 64'(last_word.keep), 64'hF);
        chk("w1_last", 64'(last_word.last), 64'd0);

        // Early tlast, then next word restarts at lane 0
        send(8'hAA, 0, 0, 0, 0);
        send(8'hBB, 1, 0, 0, 0);
        idle();
        drain();
        chk("p_data", 64'(last_word.data), 64'h0000BBAA);
        chk("p_keep", 64'(last_word.keep), 64'h3);
        chk("p_last", 64'(last_word.last), 64'd1);
        send(8'h5A, 1, 0, 0, 0);
        idle();
        drain();
        chk("lane0_data", 64'(last_word.data), 64'h5A);
        chk("lane0_keep", 64'(last_word.keep), 64'h1);

        // tid/tdest from beat 0, tuser ORed
        send(8'h01, 0, 0, 8'd5, 8'd2);
        send(8'h02, 0, 0, 8'd7, 8'd3);
        send(8'h03, 0, 1, 8'd7, 8'd3);
        send(8'h04, 0, 0, 8'd7, 8'd3);
        idle();
        drain();
        chk("side_id",   64'(last_word.id),   64'd5);
        chk("side_dest", 64'(last_word.dest), 64'd2);
        chk("side_user", 64'(last_word.user), 64'd1);

        // 16-byte stream under random backpressure
        rand_rdy = 1'b1;
        w0 = n_words;
        for (int i = 0; i < 16; i++) send(8'(8'h80 + i), 0, 0, 8'(i), 8'(i));
        idle();
        drain();
        rand_rdy = 1'b0;
        rdy_force = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rand_words", 64'(n_words - w0), 64'd4);

        // Reset mid-word discards partial lanes
        send(8'hE1, 0, 0, 0, 0);
        send(8'hE2, 0, 0, 0, 0);
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        w0 = n_words;
        send(8'h01, 0, 0, 0, 0);
        send(8'h02, 0, 0, 0, 0);
        send(8'h03, 0, 0, 0, 0);
        send(8'h04, 0, 0, 0, 0);
        idle();
        drain();
        chk("rst_words", 64'(n_words - w0), 64'd1);
        chk("rst_word",  64'(last_word.data), 64'h04030201);

        // Single-beat words every cycle: replace-while-draining, no bubble
        w0 = n_words;
        t0 = cyc;
        for (int i = 0; i < 6; i++) send(8'(8'hC0 + i), 1, 0, 0, 0);
        idle();
        drain();
        chk("b2b_words", 64'(n_words - w0), 64'd6);
        chk("b2b_fast",  64'((cyc - t0) <= 8), 64'd1);
        chk("b2b_data",  64'(last_word.data), 64'hC5);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        chk("global_timeout", 64'd1, 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
